mem_blk32: RTL
==============

Name: mem_blk32

Overview:
- iBus32 bus master (initiator) that drives a single-port 32-bit memory slave such as spram32_32k.
- Executes one block command at a time: constant fill, sequence fill, or block copy over a 15-bit word address space.
- Sits between the Forth core/boot logic and the memory bus; used for memory clear, dictionary relocation and power-on memory self-test.

Parameters:
- ASZ, 15, word address width (32K words).
- DSZ, 32, data width.
- LSZ, 16, length field width (len up to 2^ASZ words).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- bus  iBus32.master  -  drives ai[ASZ-1:0], we, vi[DSZ-1:0], bmsk[3:0]; samples vo[DSZ-1:0].
- start  in  1  command strobe, sampled only in IDLE.
- op  in  2  command: 0=FILL, 1=SEQ, 2=COPY, 3=reserved (treated as NOP, done pulse only).
- src  in  ASZ  COPY source base address.
- dst  in  ASZ  destination base address (all ops).
- len  in  LSZ  word count; 0 means nothing is transferred.
- pat  in  DSZ  FILL value / SEQ seed.
- msk  in  4  byte mask placed on bus.bmsk for every write.
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  sticky verify-mismatch flag (MEM_VERIFY_EN only, else 0).
- err_cnt  out  LSZ  mismatch count, saturating (MEM_VERIFY_EN only, else 0).

Behaviour:
- Reset (clk edge with rst_n=0): state=IDLE; bus.we=0, bus.ai=0, bus.vi=0, bus.bmsk=4'b1111; busy=0, done=0, err=0, err_cnt=0. Reset mid-command aborts immediately: no further writes occur, and no done pulse is issued.
- Command fields are latched on accept (IDLE && start). start while busy is ignored.
- States: IDLE, WR (FILL/SEQ), CRD, CWR (COPY), VRD, VCHK (verify), FIN.
- Accept with len=0 or op=3: go directly to FIN; done pulses the next cycle and the bus is untouched.
- FILL/SEQ: one write per cycle for len cycles. Word i: ai=dst+i, we=1, vi=pat (FILL) or pat+i mod 2^DSZ (SEQ), bmsk=msk. FIN follows the last write.
- COPY: 2 cycles per word. CRD drives ai=src+i, we=0. CWR drives ai=dst+i, we=1, vi=bus.vo, which is valid one cycle after the address because slave read latency is 1. Total 2*len bus cycles.
- Overlap: strictly forward, word-by-word. If dst is in (src, src+len), already-copied data propagates; this is the defined behaviour.
- Address arithmetic is modulo 2^ASZ. 'h7fff+1 wraps to 0 without error.
- FIN: done=1 for one cycle, busy=0, we=0, then IDLE. A start sampled in the FIN cycle is ignored.
- busy=1 in every state except IDLE and FIN.

Optional Feature:
- Macro MEM_VERIFY_EN.
- With it: after the last FILL/SEQ write, run a read-back pass. VRD drives ai=dst+i, we=0. The next cycle compares bus.vo against the expected word, masked per byte by msk. Each mismatch sets err and increments err_cnt, saturating at all-ones. Duration is len extra reads plus 1 cycle of pipeline drain. err and err_cnt are cleared on the next accept. COPY is never verified.
- Without it: no verify states exist; err and err_cnt are tied to 0.

Decomposition:
- Package mem_pkg holds: ASZ/DSZ/LSZ localparams; op_t enum (OP_FILL, OP_SEQ, OP_COPY, OP_NOP); state_t enum.
- Sub-module mem_agen: loadable index counter with terminal-count flag; supplies i, the base+i address sums and last.

Test Plan:
- FILL dst=0, len=4, pat='hdeadbeef, msk=4'b1111: 4 consecutive write cycles to 0..3. Readback gives 'hdeadbeef at each address; done pulses exactly once, 5 cycles after accept.
- SEQ dst='h7ffe, len=4, pat='h10: writes 'h10,'h11,'h12,'h13 to 'h7ffe,'h7fff,0,1, confirming wrap-around.
- COPY src=0, dst='h100, len=8 after SEQ pat=0: words 'h100..'h107 read 0..7, and busy lasts 16 cycles.
- len=0 accept: done pulses the next cycle, we never asserts; start pulsed during a busy FILL is ignored.
- rst_n low for 1 cycle mid-FILL at i=2 (dst=0, len=8): only addresses 0..2 are written, no done pulse, all outputs at reset values.
- MEM_VERIFY_EN: FILL len=4 pat='h55 with the slave forced to corrupt address 2 gives err=1, err_cnt=1. Repeating with msk=4'b0001 and an upper-byte corruption gives err=0.

Source files
------------

// File: rtl/mem_blk32_pkg.sv
// Shared definitions for the mem_blk32 block mover.
// Holds bus/length widths, the command opcode and FSM state enums, the
// latched command record and small data helpers.
// Optional macro MEM_VERIFY_EN adds the read-back verify states.
package mem_pkg;

  localparam int unsigned ASZ = 15;  // word address width
  localparam int unsigned DSZ = 32;  // data width
  localparam int unsigned LSZ = 16;  // length field width

  typedef enum logic [1:0] {
    OP_FILL = 2'd0,
    OP_SEQ  = 2'd1,
    OP_COPY = 2'd2,
    OP_NOP  = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_CRD,
    S_CWR,
`ifdef MEM_VERIFY_EN
    S_VRD,
    S_VCHK,
`endif
    S_FIN
  } state_t;

  typedef struct packed {
    op_t            op;
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [LSZ-1:0] len;
    logic [DSZ-1:0] pat;
    logic [3:0]     msk;
  } cmd_t;

  // Data word i of a FILL/SEQ command.
  function automatic logic [DSZ-1:0] cmd_word(input cmd_t c, input logic [LSZ-1:0] i);
    return (c.op == OP_SEQ) ? c.pat + DSZ'(i) : c.pat;
  endfunction

  // Expand a 4-bit byte mask to a full data-width bit mask.
  function automatic logic [DSZ-1:0] byte_mask(input logic [3:0] m);
    logic [DSZ-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < 4; b++) r[8*b +: 8] = {8{m[b]}};
    return r;
  endfunction

endpackage

// File: rtl/mem_blk32_if.sv
// iBus32: single-port 32-bit memory bus.
//   ai   word address        (master -> slave)
//   we   write enable        (master -> slave)
//   vi   write data          (master -> slave)
//   bmsk byte write mask     (master -> slave)
//   vo   read data, valid one cycle after ai (slave -> master)
interface iBus32 import mem_pkg::*; ();
  logic [ASZ-1:0] ai;
  logic           we;
  logic [DSZ-1:0] vi;
  logic [3:0]     bmsk;
  logic [DSZ-1:0] vo;

  modport master (output ai, we, vi, bmsk, input vo);
  modport slave  (input ai, we, vi, bmsk, output vo);
endinterface

// File: rtl/mem_blk32_agen.sv
// mem_agen: loadable word index counter for mem_blk32.
//   clk, rst_n    clock, synchronous active-low reset
//   clr           reload index to 0 (wins over inc)
//   inc           advance index by one
//   len           command word count
//   sbase, dbase  source / destination base addresses
//   idx           current word index i
//   saddr, daddr  sbase+i, dbase+i (modulo 2^ASZ)
//   last          index is at len-1
module mem_agen import mem_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  input  logic           inc,
  input  logic [LSZ-1:0] len,
  input  logic [ASZ-1:0] sbase,
  input  logic [ASZ-1:0] dbase,
  output logic [LSZ-1:0] idx,
  output logic [ASZ-1:0] saddr,
  output logic [ASZ-1:0] daddr,
  output logic           last
);

  always_ff @(posedge clk) begin
    if (!rst_n)   idx <= '0;
    else if (clr) idx <= '0;
    else if (inc) idx <= idx + LSZ'(1);
  end

  always_comb begin
    saddr = sbase + idx[ASZ-1:0];
    daddr = dbase + idx[ASZ-1:0];
    last  = (idx == len - LSZ'(1));
  end

endmodule

// File: rtl/mem_blk32.sv
// mem_blk32: iBus32 master executing one block command at a time
// (constant fill, sequence fill, forward block copy).
//   clk, rst_n  clock, synchronous active-low reset
//   bus         iBus32 master port (ai/we/vi/bmsk out, vo in)
//   start, op   command strobe (sampled in IDLE) and opcode
//   src, dst    copy source / destination base word addresses
//   len, pat    word count, fill value or sequence seed
//   msk         byte mask placed on every write
//   busy, done  command active, one-cycle completion pulse
//   err,err_cnt sticky verify mismatch flag and saturating count
// Optional macro MEM_VERIFY_EN: read-back verify after FILL/SEQ;
// without it err and err_cnt are constant 0.
module mem_blk32 import mem_pkg::*; (
  input  logic           clk,
  input  logic           rst_n,
  iBus32.master          bus,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [LSZ-1:0] len,
  input  logic [DSZ-1:0] pat,
  input  logic [3:0]     msk,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [LSZ-1:0] err_cnt
);

  state_t         state, state_nx;
  cmd_t           cmd;
  logic           accept, ag_clr, ag_inc, last;
  logic [LSZ-1:0] idx;
  logic [ASZ-1:0] saddr, daddr;

  assign accept = (state == S_IDLE) && start;

  mem_agen u_agen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (ag_clr),
    .inc   (ag_inc),
    .len   (cmd.len),
    .sbase (cmd.src),
    .dbase (cmd.dst),
    .idx   (idx),
    .saddr (saddr),
    .daddr (daddr),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cmd   <= '0;
    end else begin
      state <= state_nx;
      if (accept)
        cmd <= '{op: op_t'(op), src: src, dst: dst, len: len, pat: pat, msk: msk};
    end
  end

  // Bus outputs decode from state so reset/IDLE values appear directly.
  always_comb begin
    state_nx = state;
    ag_clr   = 1'b0;
    ag_inc   = 1'b0;
    bus.we   = 1'b0;
    bus.ai   = '0;
    bus.vi   = '0;
    bus.bmsk = '1;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          ag_clr = 1'b1;
          if (len == '0 || op_t'(op) == OP_NOP) state_nx = S_FIN;
          else if (op_t'(op) == OP_COPY)        state_nx = S_CRD;
          else                                  state_nx = S_WR;
        end
      end
      S_WR: begin
        busy     = 1'b1;
        bus.we   = 1'b1;
        bus.ai   = daddr;
        bus.vi   = cmd_word(cmd, idx);
        bus.bmsk = cmd.msk;
        if (last) begin
`ifdef MEM_VERIFY_EN
          state_nx = S_VRD;
          ag_clr   = 1'b1;
`else
          state_nx = S_FIN;
`endif
        end else begin
          ag_inc = 1'b1;
        end
      end
      S_CRD: begin
        busy     = 1'b1;
        bus.ai   = saddr;
        state_nx = S_CWR;
      end
      S_CWR: begin
        // Read data from the preceding CRD cycle arrives on vo now.
        busy     = 1'b1;
        bus.we   = 1'b1;
        bus.ai   = daddr;
        bus.vi   = bus.vo;
        bus.bmsk = cmd.msk;
        if (last) begin
          state_nx = S_FIN;
        end else begin
          state_nx = S_CRD;
          ag_inc   = 1'b1;
        end
      end
`ifdef MEM_VERIFY_EN
      S_VRD: begin
        busy   = 1'b1;
        bus.ai = daddr;
        if (last) state_nx = S_VCHK;
        else      ag_inc   = 1'b1;
      end
      S_VCHK: begin
        busy     = 1'b1;
        state_nx = S_FIN;
      end
`endif
      S_FIN: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef MEM_VERIFY_EN
  // Compare runs one cycle behind VRD to match the slave read latency.
  logic           chk_vld, miss;
  logic [DSZ-1:0] chk_exp;

  always_comb miss = chk_vld && (((bus.vo ^ chk_exp) & byte_mask(cmd.msk)) != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chk_vld <= 1'b0;
      chk_exp <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      chk_vld <= (state == S_VRD);
      chk_exp <= cmd_word(cmd, idx);
      if (accept) begin
        err     <= 1'b0;
        err_cnt <= '0;
      end else if (miss) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + LSZ'(1);
      end
    end
  end
`else
  always_comb begin
    err     = 1'b0;
    err_cnt = '0;
  end
`endif

endmodule
